output_requantizer: RTL and testbench

OUTPUT_REQUANTIZER -- requirements
Module: output_requantizer

---
 rtl/output_requantizer_pkg.sv | 34 +++
 rtl/output_requantizer_lane.sv | 45 ++++
 rtl/output_requantizer.sv | 121 ++++++++++++
 tb/tb_output_requantizer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_requantizer_pkg.sv
// Shared accelerator definitions: default geometry, datapath widths and the
// requantization parameter set latched by output_requantizer.
package output_requantizer_pkg;

  localparam int PP_PAR_DEF     = 8;
  localparam int OC_PAR_DEF     = 16;
  localparam int ACC_WIDTH_DEF  = 28;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MULT_WIDTH_DEF = 16;

  localparam int BIAS_WIDTH  = 32;
  localparam int SHIFT_WIDTH = 5;
  localparam int SUM_WIDTH   = BIAS_WIDTH + 1;
  // Signed sum times zero-extended (one extra sign bit) multiplier.
  localparam int PROD_WIDTH  = SUM_WIDTH + MULT_WIDTH_DEF + 1;

  // Sized by the package defaults; instances must not exceed OC_PAR_DEF channels
  // or MULT_WIDTH_DEF multiplier bits.
  typedef struct packed {
    logic [OC_PAR_DEF-1:0][BIAS_WIDTH-1:0]     bias;
    logic [OC_PAR_DEF-1:0][MULT_WIDTH_DEF-1:0] mult;
    logic [SHIFT_WIDTH-1:0]                    shift;
    logic                                      relu;
  } requant_params_t;

  // Identity requantization: bias 0, mult 1, no shift, ReLU off.
  function automatic requant_params_t params_reset();
    requant_params_t p;
    p = '0;
    for (int c = 0; c < OC_PAR_DEF; c++) p.mult[c] = MULT_WIDTH_DEF'(1);
    return p;
  endfunction

endpackage

// File: rtl/output_requantizer_lane.sv
// One lane of the final stage: round-half-up right shift, optional ReLU and
// saturation to the signed output range.
module requant_lane
  import output_requantizer_pkg::*;
#(
  parameter int IN_WIDTH   = PROD_WIDTH,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [IN_WIDTH-1:0]    prod,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu_en,
  output logic signed [DATA_WIDTH-1:0]  data,
  output logic                          sat
);

  // One guard bit so the rounding increment can never wrap.
  localparam int EW = IN_WIDTH + 1;
  localparam logic signed [EW-1:0] MAX_V = EW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] MIN_V = -MAX_V - EW'(1);

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] half;
  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] rect;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    ext  = EW'(prod);
    half = '0;
    if (shift != '0) half = EW'(1) <<< (shift - SHIFT_WIDTH'(1));
    rounded = (ext + half) >>> shift;
    rect    = (relu_en && rounded[EW-1]) ? '0 : rounded;
    sat     = 1'b0;
    data    = rect[DATA_WIDTH-1:0];
    if (rect > MAX_V) begin
      data = MAX_V[DATA_WIDTH-1:0];
      sat  = 1'b1;
    end else if (rect < MIN_V) begin
      data = MIN_V[DATA_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/output_requantizer.sv
// Three-stage requantizer: bias add, per-channel multiply, then per-lane
// round/shift/ReLU/saturate, with a single stall-propagating handshake.
module output_requantizer
  import output_requantizer_pkg::*;
#(
  parameter int PP_PAR     = PP_PAR_DEF,
  parameter int OC_PAR     = OC_PAR_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MULT_WIDTH = MULT_WIDTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [PP_PAR*OC_PAR*ACC_WIDTH-1:0]     acc_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [OC_PAR*BIAS_WIDTH-1:0]           bias_in,
  input  logic [OC_PAR*MULT_WIDTH-1:0]           mult_in,
  input  logic [SHIFT_WIDTH-1:0]                 shift_in,
  input  logic                                   relu_en_in,
  input  logic                                   params_load,
  output logic [PP_PAR*OC_PAR*DATA_WIDTH-1:0]    pix_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [15:0]                            sat_count,
  output logic                                   param_err,
  input  logic                                   stat_clear
);

  localparam int LANES = PP_PAR * OC_PAR;

  requant_params_t params;
  requant_params_t new_params;

  logic adv;
  logic load_ok;
  logic s1_valid;
  logic s2_valid;
  logic out_sat;

  logic signed [SUM_WIDTH-1:0]  s1_sum    [PP_PAR][OC_PAR];
  logic signed [PROD_WIDTH-1:0] s2_prod   [PP_PAR][OC_PAR];
  logic signed [DATA_WIDTH-1:0] lane_data [PP_PAR][OC_PAR];
  logic        [LANES-1:0]      lane_sat;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  // Parameters may only change with the pipeline empty and nothing arriving.
  assign load_ok  = params_load && !s1_valid && !s2_valid && !out_valid && !in_valid;

  always_comb begin
    new_params       = params;
    new_params.shift = shift_in;
    new_params.relu  = relu_en_in;
    for (int c = 0; c < OC_PAR; c++) begin
      new_params.bias[c] = bias_in[c*BIAS_WIDTH +: BIAS_WIDTH];
      new_params.mult[c] = MULT_WIDTH_DEF'(mult_in[c*MULT_WIDTH +: MULT_WIDTH]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage ordering inside a block never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      params    <= params_reset();
      sat_count <= '0;
      param_err <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid  <= in_valid;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
      end
      if (load_ok) params <= new_params;
      if (stat_clear) begin
        sat_count <= '0;
        param_err <= 1'b0;
      end else begin
        if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
          sat_count <= sat_count + 16'd1;
        if (params_load && !load_ok) param_err <= 1'b1;
      end
    end
  end

  // NOTE: wide datapath registers carry no reset; only the valid bits decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int p = 0; p < PP_PAR; p++) begin
        for (int c = 0; c < OC_PAR; c++) begin
          s1_sum[p][c] <= SUM_WIDTH'($signed(acc_in[(p*OC_PAR+c)*ACC_WIDTH +: ACC_WIDTH]))
                        + SUM_WIDTH'($signed(params.bias[c]));
          s2_prod[p][c] <= PROD_WIDTH'(s1_sum[p][c])
                         * PROD_WIDTH'($signed({1'b0, params.mult[c]}));
          pix_out[(p*OC_PAR+c)*DATA_WIDTH +: DATA_WIDTH] <= lane_data[p][c];
        end
      end
      out_sat <= |lane_sat;
    end
  end

  for (genvar gp = 0; gp < PP_PAR; gp++) begin : g_pix
    for (genvar gc = 0; gc < OC_PAR; gc++) begin : g_ch
      requant_lane #(
        .IN_WIDTH  (PROD_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
        .prod   (s2_prod[gp][gc]),
        .shift  (params.shift),
        .relu_en(params.relu),
        .data   (lane_data[gp][gc]),
        .sat    (lane_sat[gp*OC_PAR+gc])
      );
    end
  end

endmodule

// File: tb/tb_output_requantizer.sv
// Scoreboard bench for output_requantizer: directed beats push expected outputs,
// a negedge monitor pops and compares every transferred beat.
module tb_output_requantizer;

  localparam int PP    = 8;
  localparam int OC    = 16;
  localparam int AW    = 28;
  localparam int DW    = 8;
  localparam int MW    = 16;
  localparam int LANES = PP * OC;

  typedef logic [LANES*AW-1:0] acc_t;
  typedef logic [LANES*DW-1:0] pix_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  acc_t               acc_in = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [OC*32-1:0]   bias_in = '0;
  logic [OC*MW-1:0]   mult_in = '0;
  logic [4:0]         shift_in = '0;
  logic               relu_en_in = 1'b0;
  logic               params_load = 1'b0;
  pix_t               pix_out;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [15:0]        sat_count;
  logic               param_err;
  logic               stat_clear = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  pix_t exp_q[$];

  output_requantizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_in     (acc_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bias_in    (bias_in),
    .mult_in    (mult_in),
    .shift_in   (shift_in),
    .relu_en_in (relu_en_in),
    .params_load(params_load),
    .pix_out    (pix_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_count  (sat_count),
    .param_err  (param_err),
    .stat_clear (stat_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pix(input string name, input pix_t act, input pix_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < LANES; i++) begin
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s lane %0d got %0d expected %0d", name, i,
                   $signed(act[i*DW +: DW]), $signed(exp[i*DW +: DW]));
          break;
        end
      end
    end
  endtask

  function automatic acc_t fill_acc(input int v);
    acc_t a;
    for (int i = 0; i < LANES; i++) a[i*AW +: AW] = AW'(v);
    return a;
  endfunction

  function automatic pix_t fill_pix(input int v);
    pix_t p;
    for (int i = 0; i < LANES; i++) p[i*DW +: DW] = DW'(v);
    return p;
  endfunction

  // Scoreboard monitor: every transferred beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got a beat expected none");
      end else begin
        check_pix("pix_out", pix_out, exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input acc_t a, input pix_t e);
    int n = 0;
    acc_in   = a;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready 0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(e);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input int bias_v, input int mult_v, input int shift_v,
                      input bit relu_v, input bit per_ch);
    for (int c = 0; c < OC; c++) begin
      bias_in[c*32 +: 32] = 32'(bias_v + (per_ch ? c : 0));
      mult_in[c*MW +: MW] = MW'(mult_v);
    end
    shift_in    = 5'(shift_v);
    relu_en_in  = relu_v;
    params_load = 1'b1;
    @(posedge clk);
    #1;
    params_load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 200);
    if (exp_q.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pix_t held;
    pix_t e;
    acc_t a;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sat_count", sat_count, 0);
    check("rst_param_err", param_err, 0);
    @(posedge clk);
    #1;

    // 960 >> 3 = 120, three cycles after the transfer.
    load(0, 1, 3, 1'b0, 1'b0);
    check("load_ok_param_err", param_err, 0);
    send(fill_acc(960), fill_pix(120));
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    check("latency", cyc - acc_cyc, 3);
    drain();
    check("sat_count_none", sat_count, 0);

    // Positive and negative saturation, one count per saturated beat.
    load(0, 1, 0, 1'b0, 1'b0);
    send(fill_acc(960), fill_pix(127));
    drain();
    check("sat_count_pos", sat_count, 1);
    send(fill_acc(-960), fill_pix(-128));
    drain();
    check("sat_count_neg", sat_count, 2);

    // ReLU zeroing is not saturation.
    load(0, 1, 0, 1'b1, 1'b0);
    send(fill_acc(-100), fill_pix(0));
    drain();
    check("sat_count_relu", sat_count, 2);
    load(0, 1, 0, 1'b0, 1'b0);
    send(fill_acc(-100), fill_pix(-100));
    drain();

    // Round half up: (5+1)>>1=3, (-5+1)>>>1=-2, (4-10+1)>>>1=-3.
    load(0, 1, 1, 1'b0, 1'b0);
    send(fill_acc(5), fill_pix(3));
    send(fill_acc(-5), fill_pix(-2));
    drain();
    load(-10, 1, 1, 1'b0, 1'b0);
    send(fill_acc(4), fill_pix(-3));
    drain();

    // Per-channel bias c, mult 2, shift 1: ((10+c)*2+1)>>1 = 10+c.
    load(0, 2, 1, 1'b0, 1'b1);
    for (int i = 0; i < LANES; i++) e[i*DW +: DW] = DW'(10 + (i % OC));
    send(fill_acc(10), e);
    drain();

    // Lane mapping with identity params: lane i carries i-64.
    load(0, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < LANES; i++) begin
      a[i*AW +: AW] = AW'(i - 64);
      e[i*DW +: DW] = DW'(i - 64);
    end
    send(a, e);
    drain();

    // Backpressure: four beats, out_ready low for five cycles.
    out_ready = 1'b0;
    fork
      begin
        send(fill_acc(11), fill_pix(11));
        send(fill_acc(22), fill_pix(22));
        send(fill_acc(33), fill_pix(33));
        send(fill_acc(44), fill_pix(44));
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        held = pix_out;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check_pix("stall_hold", pix_out, held);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Rejected load while a beat is in flight: params stay identity.
    send(fill_acc(50), fill_pix(50));
    load(0, 1, 7, 1'b1, 1'b0);
    check("param_err_set", param_err, 1);
    send(fill_acc(50), fill_pix(50));
    drain();
    check("sat_count_before_clear", sat_count, 2);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    check("param_err_clear", param_err, 0);
    check("sat_count_clear", sat_count, 0);

    // Reset with two beats in flight discards them.
    send(fill_acc(60), fill_pix(60));
    send(fill_acc(61), fill_pix(61));
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(fill_acc(77), fill_pix(77));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
